// File: rtl/pc_branch_unit.sv
// Next-PC stage: evaluates branch conditions from held flags, owns the PC register,
// and issues a one-cycle flush to fetch/decode on every taken branch.
module pc_branch_unit #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              br_valid,
  input  logic              uncond_br,
  input  logic              br_reg,
  input  logic              cond_br,
  input  logic              cbz,
  input  logic [3:0]        cond,
  input  logic [25:0]       imm26,
  input  logic [18:0]       imm19,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              neg,
  input  logic              zero,
  input  logic              of,
  input  logic              co,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              br_taken,
  output logic              flush
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              br_taken_reg, br_taken_next;
  logic              flush_reg, flush_next;
  logic              br_hit;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] off26, off19;
  logic [7:0]        cond_base;
  logic [15:0]       cond_hit;

  // Even condition codes are the base test, odd codes its inverse (except 1111 = always).
  assign cond_base = {1'b1, ~zero & (neg == of), (neg == of), co & ~zero, of, neg, co, zero};

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_cond
      assign cond_hit[2*gi] = cond_base[gi];
      if (gi == 7) begin : g_al
        assign cond_hit[2*gi+1] = 1'b1;
      end else begin : g_inv
        assign cond_hit[2*gi+1] = ~cond_base[gi];
      end
    end
  endgenerate

  assign off26    = {{(ADDR_W-28){imm26[25]}}, imm26, 2'b00};
  assign off19    = {{(ADDR_W-21){imm19[18]}}, imm19, 2'b00};
  assign pc_plus4 = pc_reg + ADDR_W'(4);

  // Branch inputs belong to a squashed instruction while in FLUSH.
  always_comb begin
    br_hit    = 1'b0;
    br_target = reg_target;
    if (state_reg == RUN && br_valid) begin
      if (br_reg) begin
        br_hit    = 1'b1;
        br_target = reg_target;
      end else if (uncond_br) begin
        br_hit    = 1'b1;
        br_target = br_pc + off26;
      end else if (cbz) begin
        br_hit    = zero;
        br_target = br_pc + off19;
      end else if (cond_br) begin
        br_hit    = cond_hit[cond];
        br_target = br_pc + off19;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (!stall) begin
      case (state_reg)
        RUN:     if (br_hit) state_next = FLUSH;
        FLUSH:   state_next = RUN;
        default: state_next = RUN;
      endcase
    end
  end

  always_comb begin
    pc_next       = pc_reg;
    br_taken_next = br_taken_reg;
    flush_next    = flush_reg;
    if (!stall) begin
      if (br_hit) begin
        pc_next       = br_target;
        br_taken_next = 1'b1;
      end else begin
        pc_next       = pc_plus4;
        br_taken_next = 1'b0;
      end
      flush_next = (state_next == FLUSH);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg       <= RESET_PC;
      br_taken_reg <= 1'b0;
      flush_reg    <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      br_taken_reg <= br_taken_next;
      flush_reg    <= flush_next;
    end
  end

  assign pc       = pc_reg;
  assign br_taken = br_taken_reg;
  assign flush    = flush_reg;

endmodule
